// File: rtl/if_id_stage_buf_if.sv
// if_id_stage_buf_if: IF->buffer and buffer->ID handshake bundle
interface if_id_stage_buf_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic          if_valid;
    logic [31:0]   if_pc;
    logic [31:0]   if_inst;
    logic          if_ready;
    logic          id_ready;
    logic          flush;
    logic          id_valid;
    logic [31:0]   id_pc;
    logic [31:0]   id_inst;
    logic [4:0]    id_rs;
    logic [4:0]    id_rt;
    logic [CW-1:0] id_count;
    modport master (
        output if_valid, if_pc, if_inst, id_ready, flush,
        input  if_ready, id_valid, id_pc, id_inst, id_rs, id_rt, id_count
    );
    modport slave (
        input  if_valid, if_pc, if_inst, id_ready, flush,
        output if_ready, id_valid, id_pc, id_inst, id_rs, id_rt, id_count
    );
endinterface

// File: rtl/if_id_stage_buf.sv
// if_id_stage_buf: IF/ID instruction buffer; optional perf counters via IF_ID_PERF_CNT_EN
module if_id_stage_buf #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0340_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    if_id_stage_buf_if.slave    bus
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [31:0]         perf_stall_cycles,
    output logic [31:0]         perf_flush_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   mem_pc_q   [DEPTH];
    logic [31:0]   mem_pc_d   [DEPTH];
    logic [31:0]   mem_inst_q [DEPTH];
    logic [31:0]   mem_inst_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop, head_valid;
    logic [31:0]   head_inst;
    logic          rt_is_rd;

    // if_ready depends only on registered occupancy, so a pop never frees a slot in the same cycle
    assign bus.if_ready = count_q < CW'(DEPTH);
    assign head_valid   = count_q != '0;
    assign push         = bus.if_valid & bus.if_ready & ~bus.flush;
    assign pop          = head_valid & bus.id_ready & ~bus.flush;

    // next-state for storage, pointers and occupancy; flush overrides everything
    always_comb begin
        mem_pc_d   = mem_pc_q;
        mem_inst_d = mem_inst_q;
        if (push) begin
            mem_pc_d[wr_ptr_q]   = bus.if_pc;
            mem_inst_d[wr_ptr_q] = bus.if_inst;
        end
        wr_ptr_d = bus.flush ? '0 : wr_ptr_q + PW'(push);
        rd_ptr_d = bus.flush ? '0 : rd_ptr_q + PW'(pop);
        count_d  = bus.flush ? '0 : count_q + CW'(push) - CW'(pop);
    end

    // state registers, cleared asynchronously so reset drops entries without a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_pc_q   <= '{default: '0};
            mem_inst_q <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            mem_pc_q   <= mem_pc_d;
            mem_inst_q <= mem_inst_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // head presentation; empty shows a NOP with r0 sources so forwarding never falsely matches
    always_comb begin
        head_inst    = head_valid ? mem_inst_q[rd_ptr_q] : NOP_INST;
        rt_is_rd     = (head_inst[31:26] >= 6'b010110 && head_inst[31:26] <= 6'b011011) ||
                       (head_inst[31:22] >= 10'b0010100100 && head_inst[31:22] <= 10'b0010100110);
        bus.id_valid = head_valid;
        bus.id_pc    = head_valid ? mem_pc_q[rd_ptr_q] : '0;
        bus.id_inst  = head_inst;
        bus.id_rs    = head_valid ? head_inst[9:5] : '0;
        bus.id_rt    = !head_valid ? '0 : rt_is_rd ? head_inst[4:0] : head_inst[14:10];
        bus.id_count = count_q;
    end

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // wrapping event counters for stalled-head cycles and redirect flushes
    always_comb begin
        stall_cnt_d = stall_cnt_q + 32'(head_valid & ~bus.id_ready & ~bus.flush);
        flush_cnt_d = flush_cnt_q + 32'(bus.flush);
    end

    // perf counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_flush_cnt    = flush_cnt_q;
`endif
endmodule

// File: tb/tb_if_id_stage_buf.sv
// tb_if_id_stage_buf: queue-model checked bench for if_id_stage_buf
module tb_if_id_stage_buf;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0340_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    if_id_stage_buf_if #(.DEPTH(DEPTH)) bus ();
    if_id_stage_buf #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;
    logic [63:0] q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] exp_rt(input logic [31:0] i);
        int op6, op10;
        op6  = int'(i[31:26]);
        op10 = int'(i[31:22]);
        return ((op6 >= 22 && op6 <= 27) || (op10 >= 164 && op10 <= 166)) ? i[4:0] : i[14:10];
    endfunction

    task automatic check_model();
        bit          v;
        logic [31:0] hp, hi;
        v  = q.size() != 0;
        hp = v ? q[0][63:32] : 32'h0;
        hi = v ? q[0][31:0] : NOP;
        chk("id_valid", 32'(bus.id_valid), 32'(v));
        chk("id_pc", bus.id_pc, hp);
        chk("id_inst", bus.id_inst, hi);
        chk("id_rs", 32'(bus.id_rs), v ? 32'(hi[9:5]) : 32'h0);
        chk("id_rt", 32'(bus.id_rt), v ? 32'(exp_rt(hi)) : 32'h0);
        chk("id_count", 32'(bus.id_count), 32'(q.size()));
        chk("if_ready", 32'(bus.if_ready), 32'(q.size() < DEPTH));
    endtask

    task automatic cyc(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                       input bit rdy, input bit fl);
        bit push, pop;
        @(negedge clk);
        bus.if_valid = v;
        bus.if_pc    = pc;
        bus.if_inst  = inst;
        bus.id_ready = rdy;
        bus.flush    = fl;
        #1 check_model();
        push = v && q.size() < DEPTH && !fl;
        pop  = q.size() != 0 && rdy && !fl;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back({pc, inst});
        end
    endtask

    task automatic idle_inputs();
        bus.if_valid = 1'b0;
        bus.if_pc    = 32'h0;
        bus.if_inst  = 32'h0;
        bus.id_ready = 1'b0;
        bus.flush    = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        case ($urandom % 4)
            0: return $urandom;
            1: return {6'(22 + $urandom % 6), 26'($urandom)};
            2: return {10'(164 + $urandom % 4), 22'($urandom)};
            default: return {($urandom % 2) ? 6'd21 : 6'd28, 26'($urandom)};
        endcase
    endfunction

    initial begin
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_inst", bus.id_inst, NOP);
        chk("rst_valid", 32'(bus.id_valid), 32'h0);
        chk("rst_ready", 32'(bus.if_ready), 32'h1);
        cyc(0, 0, 0, 1, 0);

        // streaming back to back with ID always ready
        cyc(1, 32'h1c00_0000, 32'h0280_0421, 1, 0);
        #2;
        chk("stream_rs", 32'(bus.id_rs), 32'h1);
        chk("stream_rt", 32'(bus.id_rt), 32'h1);
        cyc(1, 32'h1c00_0004, 32'h0280_0421, 1, 0);
        #2 chk("stream_cnt", 32'(bus.id_count), 32'h1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // stall fill: third push must be held off
        cyc(1, 32'h1c00_0010, 32'h0280_0421, 0, 0);
        cyc(1, 32'h1c00_0014, 32'h5800_1485, 0, 0);
        #2;
        chk("full_cnt", 32'(bus.id_count), 32'h2);
        chk("full_rdy", 32'(bus.if_ready), 32'h0);
        cyc(1, 32'h1c00_0018, 32'h2980_00e6, 0, 0);
        cyc(0, 0, 0, 1, 0);
        #2 chk("pop_rdy", 32'(bus.if_ready), 32'h1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // branch and store field selection at the head
        cyc(1, 32'h1c00_0020, 32'h5800_1485, 0, 0);
        #2;
        chk("beq_rs", 32'(bus.id_rs), 32'h4);
        chk("beq_rt", 32'(bus.id_rt), 32'h5);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 32'h1c00_0024, 32'h2980_00e6, 0, 0);
        #2;
        chk("stw_rs", 32'(bus.id_rs), 32'h7);
        chk("stw_rt", 32'(bus.id_rt), 32'h6);
        cyc(0, 0, 0, 1, 0);

        // flush with two entries and a same-cycle fetch
        cyc(1, 32'h1c00_0030, 32'h0280_0421, 0, 0);
        cyc(1, 32'h1c00_0034, 32'h0280_0421, 0, 0);
        cyc(1, 32'h1c00_0038, 32'h0280_0421, 0, 1);
        #2 chk("flush_cnt", 32'(bus.id_count), 32'h0);
        cyc(1, 32'h1c00_0100, 32'h0280_0421, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 1, 1);

        // async reset between edges with two entries held
        cyc(1, 32'h1c00_0200, 32'h0280_0421, 0, 0);
        cyc(1, 32'h1c00_0204, 32'h0280_0421, 0, 0);
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.id_valid), 32'h0);
        chk("arst_cnt", 32'(bus.id_count), 32'h0);
        chk("arst_inst", bus.id_inst, NOP);
        chk("arst_ready", 32'(bus.if_ready), 32'h1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic
        for (int n = 0; n < 600; n++)
            cyc($urandom % 4 != 0, {$urandom, 2'b00} >> 2 << 2, rand_inst(),
                $urandom % 3 != 0, $urandom % 16 == 0);
        cyc(0, 0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_id_stage_buf.md
Name: if_id_stage_buf

Overview:
- IF/ID pipeline stage with a small instruction buffer for the 5-stage LoongArch core.
- Accepts fetched PC/instruction pairs from IF and presents the oldest one to ID.
- Extracts the source register fields (rs/rt) consumed by the branch-forwarding and hazard logic.
- Absorbs the in-flight fetch return when ID stalls (synchronous inst SRAM), and drops all buffered entries on a redirect flush.

Parameters:
DEPTH, 2, buffer entries (power of 2, >=2)
NOP_INST, 32'h0340_0000, instruction presented when empty (andi r0,r0,0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_valid  in  1  IF presents a fetched instruction
if_pc  in  32  PC of fetched instruction
if_inst  in  32  fetched instruction word
if_ready  out  1  buffer can accept this cycle
id_ready  in  1  ID consumes head this cycle (= !stall from hazard unit)
flush  in  1  branch/jump redirect: discard all buffered entries
id_valid  out  1  head entry valid
id_pc  out  32  head PC
id_inst  out  32  head instruction (NOP_INST when empty)
id_rs  out  5  head rj field, inst[9:5]; 0 when empty
id_rt  out  5  second source: inst[4:0] for branches/stores, else inst[14:10]; 0 when empty
id_count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (async, rst_n=0): count=0, rd/wr pointers=0, id_valid=0, id_pc=0, id_inst=NOP_INST, id_rs=0, id_rt=0, if_ready=1. Reset mid-operation discards all entries immediately.
- Storage: circular FIFO of DEPTH {pc,inst}. Pointers wrap modulo DEPTH.
- push = if_valid & if_ready & !flush; pop = id_valid & id_ready & !flush.
- if_ready = (count < DEPTH), from registered count only. There is no combinational path from id_ready to if_ready. When full, a simultaneous pop does not enable a push.
- Latency: an entry pushed into an empty buffer appears on id_* on the next rising edge. Throughput is 1/cycle when id_ready is held high.
- Simultaneous push and pop: count unchanged, both pointers advance. The new head is the next-oldest entry, or the pushed entry if it was the only other one.
- Empty with pop requested: no effect (pop is gated by id_valid).
- flush: has priority over push and pop. Next cycle count=0, pointers reset to 0, id_valid=0, and the same-cycle if_* input is discarded. Flush with an empty buffer is harmless.
- id_* outputs are combinational reads of the head entry, qualified by count!=0. When empty: id_inst=NOP_INST, id_rs=id_rt=0. This guarantees no false forwarding match, because forwarding excludes r0.
- id_rt selection:
  - Select inst[4:0] when inst[31:26] is in 6'b010110..6'b011011 (beq/bne/blt/bge/bltu/bgeu).
  - Also select inst[4:0] when inst[31:22] is in {10'b0010100100, 10'b0010100101, 10'b0010100110} (st.b/h/w).
  - Otherwise select inst[14:10].
- id_count equals the registered count.

Optional Feature:
IF_ID_PERF_CNT_EN
- Defined: adds outputs perf_stall_cycles[31:0] and perf_flush_cnt[31:0], both reset to 0.
  - perf_stall_cycles increments each cycle with id_valid & !id_ready & !flush.
  - perf_flush_cnt increments each cycle with flush=1.
  - Both counters wrap from 32'hFFFF_FFFF to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset then idle: after rst_n deassert, id_valid=0, id_inst=32'h0340_0000, id_rs=id_rt=0, if_ready=1, id_count=0.
- Streaming: id_ready=1; push pc 0x1c000000/0x1c000004 with inst 0x02800421 (addi.w r1,r1,1) back to back → each appears 1 cycle later, id_rs=1, id_rt=1 (inst[14:10]), id_count stays 1.
- Stall fill: id_ready=0, push 3 instrs → after 2 pushes id_count=2, if_ready=0, third held off; release id_ready → entries emerge in order, if_ready returns 1 the cycle after the first pop.
- Branch field select: push beq r4,r5 (inst 0x58001485) → id_rs=4, id_rt=5. Push st.w r6,r7,0 (0x298000e6) → id_rs=7, id_rt=6.
- Flush: buffer holds 2 entries, assert flush together with if_valid → next cycle id_valid=0, id_count=0, flushed input absent; following push appears normally.
- Async reset mid-stream: drop rst_n between edges with count=2 → outputs return to reset values immediately, with no clock edge needed.
